// File: rtl/seq_array_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_array_mult
// Description : Sequential shift-and-add WIDTH x WIDTH multiplier with
//               signed/unsigned mode and valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_array_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int                     c_CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0]     c_LAST    = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]     c_CNT_ONE = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]       c_ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]     c_ONE_P   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mag_m;
    logic [WIDTH-1:0]     r_mag_q;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [WIDTH-1:0]     w_mag_m;
    logic [WIDTH-1:0]     w_mag_q;
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_last;

    // The most-negative operand maps to 2^(WIDTH-1), still representable unsigned.
    assign w_mag_m  = (signed_mode && m[WIDTH-1]) ? (~m + c_ONE_W) : m;
    assign w_mag_q  = (signed_mode && q[WIDTH-1]) ? (~q + c_ONE_W) : q;
    assign w_neg    = signed_mode & (m[WIDTH-1] ^ q[WIDTH-1]);

    assign w_addend = {{WIDTH{1'b0}}, r_mag_m} << r_count;
    assign w_sum    = r_acc + (r_mag_q[r_count] ? w_addend : '0);
    assign w_res    = r_neg ? (~w_sum + c_ONE_P) : w_sum;
    assign w_last   = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mag_m     <= '0;
            r_mag_q     <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_p         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mag_m    <= w_mag_m;
                        r_mag_q    <= w_mag_q;
                        r_neg      <= w_neg;
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_count     <= '0;
                        r_p         <= w_res;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_count <= r_count + c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_array_mult
// Description : Self-checking bench for seq_array_mult (WIDTH=4 and WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_array_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [3:0]  m, q;
    logic [7:0]  p;
    logic        in_valid8, in_ready8, signed_mode8, out_valid8, out_ready8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic       s;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    seq_array_mult #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .m(m), .q(q), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .busy(busy)
    );

    seq_array_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .m(m8), .q(q8), .signed_mode(signed_mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .p(p8), .busy(busy8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic on the operands' numeric values.
    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int x, y;
        x = int'(a);
        y = int'(b);
        if (s && a[3]) x -= 16;
        if (s && b[3]) y -= 16;
        return 8'(x * y);
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                          output logic [7:0] res, output int e);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; m = a; q = b; signed_mode = s;
        @(negedge clk);
        in_valid = 1'b0;
        m = 4'($urandom); q = 4'($urandom); signed_mode = 1'($urandom);
        chk("busy_after_accept", 32'({in_ready, busy, out_valid}), 32'b010);
        e = 1;
        while (!out_valid && e < 40) begin @(negedge clk); e++; end
        chk("ready_vs_valid", 32'(in_ready), 32'd0);
        res = p;
    endtask

    task automatic finish_op();
        @(negedge clk);
        chk("release", 32'({in_ready, out_valid, busy}), 32'b100);
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [15:0] exp);
        int e;
        in_valid8 = 1'b1; m8 = a; q8 = b; signed_mode8 = s;
        @(negedge clk);
        in_valid8 = 1'b0;
        e = 1;
        while (!out_valid8 && e < 40) begin @(negedge clk); e++; end
        chk("w8_lat", 32'(e), 32'd9);
        chk("w8_p", 32'(p8), 32'(exp));
        @(negedge clk);
        chk("w8_release", 32'({in_ready8, out_valid8}), 32'b10);
    endtask

    initial begin
        logic [7:0] res;
        logic [7:0] hold;
        int         e;
        int         stall;

        tbl[0]  = '{4'd13, 4'd11, 1'b0, 8'd143};
        tbl[1]  = '{4'b1000, 4'b1000, 1'b1, 8'd64};
        tbl[2]  = '{4'b1000, 4'b0111, 1'b1, 8'hC8};
        tbl[3]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
        tbl[4]  = '{4'd3, 4'd5, 1'b0, 8'd15};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 8'h01};
        tbl[6]  = '{4'd7, 4'd7, 1'b1, 8'h31};
        tbl[7]  = '{4'd0, 4'hF, 1'b1, 8'h00};
        tbl[8]  = '{4'd7, 4'b1000, 1'b1, 8'hC8};
        tbl[9]  = '{4'hF, 4'd1, 1'b1, 8'hFF};
        tbl[10] = '{4'd1, 4'b1000, 1'b0, 8'h08};

        rst = 1'b1;
        in_valid = 1'b0; m = '0; q = '0; signed_mode = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; m8 = '0; q8 = '0; signed_mode8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("reset_p", 32'(p), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_op(tbl[i].m, tbl[i].q, tbl[i].s, res, e);
            chk("tbl_p", 32'(res), 32'(tbl[i].exp));
            chk("tbl_lat", 32'(e), 32'd5);
            finish_op();
        end

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        run_op(4'hF, 4'hF, 1'b0, res, e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold", 32'({p, out_valid, in_ready}), 32'({8'hE1, 1'b1, 1'b0}));
        end
        out_ready = 1'b1;
        finish_op();
        chk("bp_p_kept", 32'(p), 32'hE1);

        // Reset on the second BUSY cycle discards the operation.
        in_valid = 1'b1; m = 4'd9; q = 4'd6; signed_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("midrst_p", 32'(p), 32'd0);
        run_op(4'd3, 4'd5, 1'b0, res, e);
        chk("midrst_next", 32'(res), 32'd15);
        finish_op();

        // Reset while DONE with out_valid high drops the pending result.
        out_ready = 1'b0;
        run_op(4'hE, 4'hD, 1'b0, res, e);
        chk("done_p", 32'(res), 32'(ref4(4'hE, 4'hD, 1'b0)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("donerst", 32'({in_ready, out_valid, busy, p}), 32'({3'b100, 8'h00}));

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    run_op(4'(a), 4'(b), 1'(s), res, e);
                    chk("exh_p", 32'(res), 32'(ref4(4'(a), 4'(b), 1'(s))));
                    chk("exh_lat", 32'(e), 32'd5);
                    finish_op();
                end

        for (int k = 0; k < 40; k++) begin
            logic [3:0] ra, rb;
            logic       rs;
            ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
            stall = $urandom_range(0, 4);
            out_ready = (stall == 0);
            run_op(ra, rb, rs, res, e);
            chk("rnd_p", 32'(res), 32'(ref4(ra, rb, rs)));
            hold = res;
            for (int j = 0; j < stall; j++) begin
                @(negedge clk);
                chk("rnd_hold", 32'({p, out_valid, in_ready}), 32'({hold, 1'b1, 1'b0}));
            end
            out_ready = 1'b1;
            finish_op();
        end

        run_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op8(8'h80, 8'h01, 1'b1, 16'hFF80);
        run_op8(8'h80, 8'h80, 1'b1, 16'h4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/seq_array_mult.md
Name: seq_array_mult

Overview:
- Sequential, parametrised successor to the combinational 4x4 array multiplier.
- Computes a WIDTH x WIDTH product as shift-and-add, one partial-product row per clock, so area stays flat as WIDTH grows.
- Adds a signed (two's-complement) mode and valid/ready handshakes on both sides.
- Sits between the operand source (I/O pins or register file) and the result consumer in the multiplier project.

Parameters:
- WIDTH, 4, operand width in bits; legal values >= 2. Product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on m/q/signed_mode is valid.
- in_ready  output  1  block can accept an operand pair.
- m  input  WIDTH  multiplicand.
- q  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat m, q as two's complement; 0 = unsigned.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product.
- busy  output  1  high while in BUSY state.

Behaviour:
- Reset: when rst is sampled high at a rising edge, go to IDLE.
  - in_ready=1, out_valid=0, busy=0, p=0.
  - Internal accumulator and counter are cleared.
  - Reset overrides everything, including mid-BUSY or DONE with out_valid high; the pending result is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture operands.
    - Unsigned: |m| = m, |q| = q, neg = 0.
    - Signed: magnitudes of m and q as unsigned WIDTH-bit values; neg = m[MSB] ^ q[MSB].
  - Clear accumulator and counter, then go to BUSY.
  - Most-negative value: -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. No overflow is possible.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge: if bit[count] of |q| is 1, add (|m| << count) into the 2*WIDTH-bit accumulator; then count += 1.
  - After the edge that processes count = WIDTH-1, go to DONE and register the result into p:
    - acc, or the two's-complement negation of acc (mod 2^(2*WIDTH)) when neg=1;
    - set out_valid=1.
  - Input changes during BUSY are ignored.
- DONE:
  - out_valid=1; p is stable until the handshake completes.
  - On an edge with out_ready=1, set out_valid=0 and go to IDLE. p keeps its last value.
  - out_ready=0 stalls indefinitely.
- Latency:
  - Counting the accepting edge as edge 0, out_valid is first visible after edge WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles.
  - in_ready is never high in the same cycle as out_valid; no accept/release overlap.
- out_ready while in IDLE or BUSY has no effect.
- Results are exact for all operand values:
  - unsigned range 0..(2^WIDTH-1)^2;
  - signed range -2^(WIDTH-1)*(2^(WIDTH-1)-1) .. 2^(2*WIDTH-2).

Test Plan:
- WIDTH=4, reset, then in_valid with m=4'd13, q=4'd11, signed_mode=0 -> in_ready drops next cycle, out_valid after edge 4, p=8'd143.
- WIDTH=4, signed_mode=1, m=4'b1000 (-8), q=4'b1000 (-8) -> p=8'd64. Then m=4'b1000, q=4'b0111 (7) -> p=8'hC8 (-56).
- WIDTH=4, exhaustive: all 256 m/q pairs in both modes with out_ready tied high -> every p matches the reference model; each op takes exactly WIDTH+2 cycles.
- Backpressure: m=4'hF, q=4'hF unsigned, out_ready held low 10 cycles after out_valid -> p=8'hE1 stable, out_valid high, in_ready low. Release out_ready -> in_ready=1 next cycle.
- Reset mid-operation: assert rst on the second BUSY cycle -> next cycle in_ready=1, out_valid=0, p=0, busy=0. A new op 3x5 completes with p=15.
- WIDTH=8 instance: m=8'hFF, q=8'hFF unsigned -> p=16'hFE01 after 8 edges. Signed m=8'h80, q=8'h01 -> p=16'hFF80.
